// File: rtl/uart_spi_flash_seq_writer_if.sv
// Pin bundle between the UART/SPI flash writer and the board: host serial
// input plus the SPI flash bus. The master side is the writer itself.
interface uart_spi_flash_seq_writer_if;
  logic rx;
  logic miso;
  logic cs_n;
  logic sck;
  logic mosi;

  modport master (
    input  rx,
    input  miso,
    output cs_n,
    output sck,
    output mosi
  );

  modport slave (
    output rx,
    output miso,
    input  cs_n,
    input  sck,
    input  mosi
  );
endinterface

// File: rtl/uart_spi_flash_seq_writer.sv
// UART-to-SPI-flash sequential writer. Bytes received on the 8N1 UART line
// are queued in a small FIFO; each one is then written to the next flash
// address as WRITE ENABLE followed by a single-byte PAGE PROGRAM.
module uart_spi_flash_seq_writer #(
  parameter int          UART_BPS   = 9600,
  parameter int          CLK_FREQ   = 50_000_000,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          CS_GAP     = 8
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  uart_spi_flash_seq_writer_if.master      flash_io
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int BCW      = $clog2(BAUD_CNT + 1);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_CNT / 2);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam int GW       = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {SPI_IDLE, SPI_WREN, SPI_GAP, SPI_PP, SPI_GAP2} spi_state_t;

  // miso is intentionally unused: no status polling is performed
  logic unused_miso;
  assign unused_miso = flash_io.miso;

  // UART receiver state
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [BCW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_vld_q, rx_vld_d;
  logic            rx_fall;

  // FIFO state
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic            fifo_wr, fifo_rd, fifo_empty, fifo_full;

  // SPI sequencer state
  spi_state_t      spi_state_q, spi_state_d;
  logic [1:0]      phase_q, phase_d;
  logic [5:0]      sbit_q, sbit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [39:0]     shift_q, shift_d;
  logic [23:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            shifting_d;

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // Receiver next-state: mid-bit sampling, start re-check, stop-bit validation
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_vld_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == BAUD_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_vld_d   = rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver control registers and rx synchronizer
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_s1_q    <= flash_io.rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  // Receiver data shift register (no reset needed, only read on a valid pulse)
  always_ff @(posedge sys_clk) begin
    rx_shift_q <= rx_shift_d;
  end

  // A push while full is dropped unless a pop frees a slot in the same cycle
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_wr    = rx_vld_q && (!fifo_full || fifo_rd);

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // SPI sequencer next-state; outputs are derived from the next state so the
  // pins come straight from flops and track the state without lag
  always_comb begin
    spi_state_d = spi_state_q;
    phase_d     = phase_q;
    sbit_d      = sbit_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fifo_rd     = 1'b0;
    case (spi_state_q)
      SPI_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd     = 1'b1;
          data_d      = fifo_mem_q[rd_ptr_q];
          shift_d     = {8'h06, 32'h0};
          phase_d     = 2'd0;
          sbit_d      = 6'd0;
          spi_state_d = SPI_WREN;
        end
      end
      SPI_WREN, SPI_PP: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (sbit_q == ((spi_state_q == SPI_WREN) ? 6'd7 : 6'd39)) begin
            gap_d = '0;
            if (spi_state_q == SPI_WREN) begin
              spi_state_d = SPI_GAP;
            end else begin
              addr_d      = addr_q + 24'd1;
              spi_state_d = SPI_GAP2;
            end
          end else begin
            sbit_d  = sbit_q + 6'd1;
            shift_d = {shift_q[38:0], 1'b0};
          end
        end
      end
      SPI_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          shift_d     = {8'h02, addr_q, data_q};
          phase_d     = 2'd0;
          sbit_d      = 6'd0;
          spi_state_d = SPI_PP;
        end
      end
      SPI_GAP2: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) spi_state_d = SPI_IDLE;
      end
      default: spi_state_d = SPI_IDLE;
    endcase
    shifting_d = (spi_state_d == SPI_WREN) || (spi_state_d == SPI_PP);
    cs_n_d     = ~shifting_d;
    sck_d      = shifting_d & phase_d[1];
    mosi_d     = shifting_d & shift_d[39];
  end

  // SPI sequencer control registers and output pins
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      spi_state_q <= SPI_IDLE;
      phase_q     <= '0;
      sbit_q      <= '0;
      gap_q       <= '0;
      addr_q      <= START_ADDR;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      spi_state_q <= spi_state_d;
      phase_q     <= phase_d;
      sbit_q      <= sbit_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
    end
  end

  // SPI data registers (outgoing shift pattern and latched byte)
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
    data_q  <= data_d;
  end

  assign flash_io.cs_n = cs_n_q;
  assign flash_io.sck  = sck_q;
  assign flash_io.mosi = mosi_q;

endmodule

// File: tb/tb_uart_spi_flash_seq_writer.sv
// Directed bench for the UART-to-SPI-flash writer: a UART driver feeds bytes,
// a bus monitor records every cs_n window as (bit count, shifted value).
module tb_uart_spi_flash_seq_writer;

  localparam int BAUD = 52;  // 500_000 / 9600

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_spi_flash_seq_writer_if bus_a ();
  uart_spi_flash_seq_writer_if bus_b ();

  uart_spi_flash_seq_writer #(
    .UART_BPS(9600), .CLK_FREQ(500_000), .START_ADDR(24'h000000),
    .FIFO_DEPTH(16), .CS_GAP(8)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .flash_io(bus_a)
  );

  uart_spi_flash_seq_writer #(
    .UART_BPS(9600), .CLK_FREQ(500_000), .START_ADDR(24'hFFFFFF),
    .FIFO_DEPTH(16), .CS_GAP(8)
  ) dut_wrap (
    .sys_clk (clk),
    .sys_rst (rst),
    .flash_io(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] fa_bits[$];
  int          fa_len[$];
  bit          fa_sck_ok[$];
  logic [63:0] fb_bits[$];
  int          fb_len[$];

  function automatic logic [63:0] pp_val(input logic [23:0] a, input logic [7:0] d);
    return {24'h0, 8'h02, a, d};
  endfunction

  // Monitor for the main DUT: collects one record per cs_n low window
  initial begin : mon_a
    logic [63:0] d;
    int n;
    forever begin
      @(negedge bus_a.cs_n);
      d = '0;
      n = 0;
      forever begin
        @(posedge bus_a.sck or posedge bus_a.cs_n);
        if (bus_a.cs_n === 1'b1) break;
        d = {d[62:0], bus_a.mosi};
        n++;
      end
      #1;
      fa_bits.push_back(d);
      fa_len.push_back(n);
      fa_sck_ok.push_back(bus_a.sck === 1'b0);
    end
  end

  // Monitor for the wrap-around DUT
  initial begin : mon_b
    logic [63:0] d;
    int n;
    forever begin
      @(negedge bus_b.cs_n);
      d = '0;
      n = 0;
      forever begin
        @(posedge bus_b.sck or posedge bus_b.cs_n);
        if (bus_b.cs_n === 1'b1) break;
        d = {d[62:0], bus_b.mosi};
        n++;
      end
      #1;
      fb_bits.push_back(d);
      fb_len.push_back(n);
    end
  end

  task automatic clear_a();
    fa_bits.delete();
    fa_len.delete();
    fa_sck_ok.delete();
  endtask

  task automatic uart_send(input logic [7:0] b, input bit stop_bit, input bit to_b);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (to_b) bus_b.rx = fr[i];
      else      bus_a.rx = fr[i];
      repeat (BAUD) @(negedge clk);
    end
    if (to_b) bus_b.rx = 1'b1;
    else      bus_a.rx = 1'b1;
  endtask

  task automatic wait_frames_a(input int want, input int budget);
    int t = 0;
    while (fa_len.size() < want && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    bus_a.rx = 1'b1; bus_a.miso = 1'b0;
    bus_b.rx = 1'b1; bus_b.miso = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (bus_a.cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n got=%b exp=1", bus_a.cs_n); end
    n_cmp++; if (bus_a.sck !== 1'b0)  begin n_bad++; $display("FAIL reset_sck got=%b exp=0", bus_a.sck); end
    n_cmp++; if (bus_a.mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b exp=0", bus_a.mosi); end
    n_cmp++; if (bus_b.cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n_b got=%b exp=1", bus_b.cs_n); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (fa_len.size() != 0) begin n_bad++; $display("FAIL reset_idle_frames got=%0d exp=0", fa_len.size()); end
  endtask

  task automatic test_single_byte();
    clear_a();
    uart_send(8'hA5, 1'b1, 1'b0);
    wait_frames_a(2, 2000);
    repeat (300) @(negedge clk);
    n_cmp++;
    if (fa_len.size() != 2) begin
      n_bad++; $display("FAIL single_frame_count got=%0d exp=2", fa_len.size());
    end else begin
      n_cmp++;
      if (fa_len[0] != 8 || fa_bits[0] !== 64'h06) begin
        n_bad++; $display("FAIL single_wren got=%0d bits/%h exp=8 bits/%h", fa_len[0], fa_bits[0], 64'h06);
      end
      n_cmp++;
      if (fa_len[1] != 40 || fa_bits[1] !== pp_val(24'h000000, 8'hA5)) begin
        n_bad++; $display("FAIL single_pp got=%0d bits/%h exp=40 bits/%h", fa_len[1], fa_bits[1], pp_val(24'h000000, 8'hA5));
      end
      n_cmp++;
      if (fa_sck_ok[0] !== 1'b1 || fa_sck_ok[1] !== 1'b1) begin
        n_bad++; $display("FAIL single_sck_idle got=%b%b exp=11", fa_sck_ok[0], fa_sck_ok[1]);
      end
    end
    n_cmp++; if (bus_a.sck !== 1'b0) begin n_bad++; $display("FAIL single_sck_after got=%b exp=0", bus_a.sck); end
  endtask

  task automatic test_framing_error();
    clear_a();
    uart_send(8'h81, 1'b0, 1'b0);
    repeat (600) @(negedge clk);
    n_cmp++; if (fa_len.size() != 0) begin n_bad++; $display("FAIL framing_frames got=%0d exp=0", fa_len.size()); end
  endtask

  task automatic test_glitch();
    clear_a();
    @(negedge clk); bus_a.rx = 1'b0;
    @(negedge clk); bus_a.rx = 1'b1;
    repeat (700) @(negedge clk);
    n_cmp++; if (fa_len.size() != 0) begin n_bad++; $display("FAIL glitch_frames got=%0d exp=0", fa_len.size()); end
    // A good byte now must land at address 1: the bad frames consumed nothing
    uart_send(8'h3C, 1'b1, 1'b0);
    wait_frames_a(2, 2000);
    n_cmp++;
    if (fa_len.size() != 2) begin
      n_bad++; $display("FAIL after_glitch_count got=%0d exp=2", fa_len.size());
    end else begin
      n_cmp++;
      if (fa_len[1] != 40 || fa_bits[1] !== pp_val(24'h000001, 8'h3C)) begin
        n_bad++; $display("FAIL after_glitch_pp got=%0d bits/%h exp=40 bits/%h", fa_len[1], fa_bits[1], pp_val(24'h000001, 8'h3C));
      end
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int NB = 48;
    logic [7:0] b;
    clear_a();
    for (int i = 0; i < NB; i++) begin
      b = 8'(i * 5 + 3);
      uart_send(b, 1'b1, 1'b0);
    end
    wait_frames_a(2 * NB, 4000);
    repeat (300) @(negedge clk);
    n_cmp++;
    if (fa_len.size() != 2 * NB) begin
      n_bad++; $display("FAIL b2b_frame_count got=%0d exp=%0d", fa_len.size(), 2 * NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        b = 8'(i * 5 + 3);
        n_cmp++;
        if (fa_len[2*i] != 8 || fa_bits[2*i] !== 64'h06) begin
          n_bad++; $display("FAIL b2b_wren[%0d] got=%0d bits/%h exp=8 bits/%h", i, fa_len[2*i], fa_bits[2*i], 64'h06);
        end
        n_cmp++;
        if (fa_len[2*i+1] != 40 || fa_bits[2*i+1] !== pp_val(24'(2 + i), b)) begin
          n_bad++; $display("FAIL b2b_pp[%0d] got=%0d bits/%h exp=40 bits/%h", i, fa_len[2*i+1], fa_bits[2*i+1], pp_val(24'(2 + i), b));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int t = 0;
    fb_bits.delete();
    fb_len.delete();
    uart_send(8'h11, 1'b1, 1'b1);
    uart_send(8'h22, 1'b1, 1'b1);
    while (fb_len.size() < 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (fb_len.size() != 4) begin
      n_bad++; $display("FAIL wrap_frame_count got=%0d exp=4", fb_len.size());
    end else begin
      n_cmp++;
      if (fb_len[1] != 40 || fb_bits[1] !== pp_val(24'hFFFFFF, 8'h11)) begin
        n_bad++; $display("FAIL wrap_pp_first got=%h exp=%h", fb_bits[1], pp_val(24'hFFFFFF, 8'h11));
      end
      n_cmp++;
      if (fb_len[3] != 40 || fb_bits[3] !== pp_val(24'h000000, 8'h22)) begin
        n_bad++; $display("FAIL wrap_pp_second got=%h exp=%h", fb_bits[3], pp_val(24'h000000, 8'h22));
      end
    end
  endtask

  task automatic test_reset_mid_pp();
    int t = 0;
    clear_a();
    uart_send(8'h77, 1'b1, 1'b0);
    wait_frames_a(1, 1000);
    while (bus_a.cs_n !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (bus_a.cs_n !== 1'b0) begin n_bad++; $display("FAIL rst_pp_started got=%b exp=0", bus_a.cs_n); end
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus_a.cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_cs_n got=%b exp=1", bus_a.cs_n); end
    n_cmp++; if (bus_a.sck !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_sck got=%b exp=0", bus_a.sck); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_a();
    uart_send(8'h5A, 1'b1, 1'b0);
    wait_frames_a(2, 2000);
    n_cmp++;
    if (fa_len.size() != 2) begin
      n_bad++; $display("FAIL rst_after_count got=%0d exp=2", fa_len.size());
    end else begin
      n_cmp++;
      if (fa_len[1] != 40 || fa_bits[1] !== pp_val(24'h000000, 8'h5A)) begin
        n_bad++; $display("FAIL rst_after_pp got=%0d bits/%h exp=40 bits/%h", fa_len[1], fa_bits[1], pp_val(24'h000000, 8'h5A));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_wrap();
    test_reset_mid_pp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
